// File: rtl/alu_pkg.sv
// Shared opcode definitions and default vector geometry for the ALU arbiter.
package alu_pkg;

    localparam int unsigned DefaultDataWidth  = 32;
    localparam int unsigned DefaultVectorSize = 4;
    localparam int unsigned OpcodeWidth       = 5;

    // Opcodes the downstream vector ALU understands
    typedef enum logic [OpcodeWidth-1:0] {
        OpAdd   = 5'b00001,
        OpSub   = 5'b00010,
        OpMul   = 5'b00011,
        OpAnd   = 5'b01001,
        OpOr    = 5'b01010,
        OpXor   = 5'b01011,
        OpPassA = 5'b10001,
        OpPassB = 5'b10010
    } alu_opcode_e;

    // True when the opcode is one of the defined ALU operations
    function automatic logic is_legal_opcode(input logic [OpcodeWidth-1:0] op);
        logic legal;
        case (op)
            OpAdd, OpSub, OpMul, OpAnd, OpOr, OpXor, OpPassA, OpPassB: legal = 1'b1;
            default:                                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: the first requester after the last pointer (wrapping) wins.
module rr_picker #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [NumReq-1:0] grant_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    // Scan offsets 1..NumReq from the last pointer; the first hit is kept
    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cand_idx;
        grant_o  = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand     = (32'(last_i) + k) % NumReq;
            cand_idx = IdxW'(cand);
            if (!valid_o && req_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
                valid_o           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external vector ALU among NUM_REQ requesters,
// with a single registered response slot (1-cycle latency, full throughput).
// Optional macro ALU_ARBITER_OPCODE_CHECK_EN flags accepted opcodes the ALU
// does not define via o_rsp_err; without it o_rsp_err is tied low.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DefaultDataWidth,
    parameter int unsigned VECTOR_SIZE = DefaultVectorSize,
    parameter int unsigned NUM_REQ     = 4
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst,
    input  logic [NUM_REQ-1:0]                                  i_req_valid,
    output logic [NUM_REQ-1:0]                                  o_req_ready,
    input  logic [NUM_REQ-1:0][OpcodeWidth-1:0]                 i_req_opcode,
    input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] i_req_b,
    output logic [OpcodeWidth-1:0]                              o_alu_opcode,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              o_alu_a,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              o_alu_b,
    input  logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              i_alu_result,
    output logic                                                o_rsp_valid,
    input  logic                                                i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]                          o_rsp_id,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]              o_rsp_result,
    output logic                                                o_rsp_err
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [IdW-1:0]                         last_grant_q, last_grant_d;
    logic                                   rsp_valid_q, rsp_valid_d;
    logic [IdW-1:0]                         rsp_id_q, rsp_id_d;
    logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IdW-1:0]     pick_idx;
    logic               pick_valid;
    logic               can_accept;
    logic               accept;

    rr_picker #(
        .NumReq (NUM_REQ),
        .IdxW   (IdW)
    ) u_picker (
        .req_i   (i_req_valid),
        .last_i  (last_grant_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Handshake: the slot can take a new result if empty or draining this cycle
    always_comb begin
        can_accept  = !rsp_valid_q || i_rsp_ready;
        o_req_ready = '0;
        if (pick_valid && can_accept && !i_rst) begin
            o_req_ready = pick_grant;
        end
        // The picker only grants valid requesters, so any ready bit is an acceptance
        accept = |(o_req_ready & i_req_valid);
    end

    // Route the granted requester's payload to the ALU; zero when nobody requests
    always_comb begin
        o_alu_opcode = '0;
        o_alu_a      = '0;
        o_alu_b      = '0;
        if (pick_valid) begin
            o_alu_opcode = i_req_opcode[pick_idx];
            o_alu_a      = i_req_a[pick_idx];
            o_alu_b      = i_req_b[pick_idx];
        end
    end

    // Next state for the response slot and the round-robin pointer
    always_comb begin
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (accept) begin
            last_grant_d = pick_idx;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = pick_idx;
            rsp_result_d = i_alu_result;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response slot and pointer registers; reset leaves requester 0 first in line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_grant_q <= IdW'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

`ifdef ALU_ARBITER_OPCODE_CHECK_EN
    logic rsp_err_q, rsp_err_d;

    // Error flag travels with the result it describes
    always_comb begin
        rsp_err_d = rsp_err_q;
        if (accept) begin
            rsp_err_d = !is_legal_opcode(o_alu_opcode);
        end
    end

    // Error flag register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model of the arbiter.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int VS = 4;
    localparam int IW = $clog2(N);

    typedef logic [VS-1:0][DW-1:0] vec_t;

    logic                       clk;
    logic                       rst;
    logic [N-1:0]               req_valid;
    logic [N-1:0]               req_ready;
    logic [N-1:0][4:0]          req_opcode;
    logic [N-1:0][VS-1:0][DW-1:0] req_a;
    logic [N-1:0][VS-1:0][DW-1:0] req_b;
    logic [4:0]                 alu_opcode;
    vec_t                       alu_a;
    vec_t                       alu_b;
    vec_t                       alu_result;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [IW-1:0]              rsp_id;
    vec_t                       rsp_result;
    logic                       rsp_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_last;
    logic          m_rsp_valid;
    logic [IW-1:0] m_rsp_id;
    vec_t          m_rsp_res;
    logic          m_rsp_err;
    logic          m_known;

    alu_arbiter #(
        .DATA_WIDTH  (DW),
        .VECTOR_SIZE (VS),
        .NUM_REQ     (N)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_opcode (req_opcode),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_alu_opcode (alu_opcode),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .i_alu_result (alu_result),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_result (rsp_result),
        .o_rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane-wise ALU behaviour; undefined opcodes give a distinctive pattern
    function automatic vec_t alu_fn(input logic [4:0] op, input vec_t a, input vec_t b);
        vec_t r;
        for (int l = 0; l < VS; l++) begin
            case (op)
                5'b00001: r[l] = a[l] + b[l];
                5'b00010: r[l] = a[l] - b[l];
                5'b00011: r[l] = a[l] * b[l];
                5'b01001: r[l] = a[l] & b[l];
                5'b01010: r[l] = a[l] | b[l];
                5'b01011: r[l] = a[l] ^ b[l];
                5'b10001: r[l] = a[l];
                5'b10010: r[l] = b[l];
                default:  r[l] = a[l] ^ ~b[l];
            endcase
        end
        return r;
    endfunction

    always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    function automatic logic exp_err(input logic [4:0] op);
`ifdef ALU_ARBITER_OPCODE_CHECK_EN
        return !(op inside {5'b00001, 5'b00010, 5'b00011, 5'b01001,
                            5'b01010, 5'b01011, 5'b10001, 5'b10010});
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int i);
        logic [IW-1:0] ii;
        int            sel;
        ii  = IW'(i);
        sel = int'($urandom_range(0, 9));
        case (sel)
            0: req_opcode[ii] = 5'b00001;
            1: req_opcode[ii] = 5'b00010;
            2: req_opcode[ii] = 5'b00011;
            3: req_opcode[ii] = 5'b01001;
            4: req_opcode[ii] = 5'b01010;
            5: req_opcode[ii] = 5'b01011;
            6: req_opcode[ii] = 5'b10001;
            7: req_opcode[ii] = 5'b10010;
            default: req_opcode[ii] = 5'($urandom);
        endcase
        for (int l = 0; l < VS; l++) begin
            req_a[ii][l] = $urandom;
            req_b[ii][l] = $urandom;
        end
    endtask

    // One clock: compare DUT against the model, cross the edge, advance the model
    task automatic step(output int acc);
        int            g;
        logic          can;
        logic [N-1:0]  er;
        logic [4:0]    eop;
        vec_t          ea, eb;
        logic [IW-1:0] ci;
        #2;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            ci = IW'((m_last + k) % N);
            if (g < 0 && req_valid[ci]) g = int'(ci);
        end
        can = !m_rsp_valid || rsp_ready;
        er  = '0;
        acc = -1;
        eop = '0;
        ea  = '0;
        eb  = '0;
        if (g >= 0) begin
            ci  = IW'(g);
            eop = req_opcode[ci];
            ea  = req_a[ci];
            eb  = req_b[ci];
            if (!rst && can) begin
                er[ci] = 1'b1;
                acc    = g;
            end
        end
        chk("req_ready", 128'(req_ready), 128'(er));
        chk("alu_opcode", 128'(alu_opcode), 128'(eop));
        chk("alu_a", 128'(alu_a), 128'(ea));
        chk("alu_b", 128'(alu_b), 128'(eb));
        chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_valid));
        if (m_known) begin
            chk("rsp_id", 128'(rsp_id), 128'(m_rsp_id));
            chk("rsp_result", 128'(rsp_result), 128'(m_rsp_res));
            chk("rsp_err", 128'(rsp_err), 128'(m_rsp_err));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_last      = N - 1;
            m_rsp_valid = 1'b0;
            m_rsp_id    = '0;
            m_rsp_res   = '0;
            m_rsp_err   = 1'b0;
            m_known     = 1'b1;
        end else if (acc >= 0) begin
            m_last      = acc;
            m_rsp_valid = 1'b1;
            m_rsp_id    = IW'(acc);
            m_rsp_res   = alu_fn(eop, ea, eb);
            m_rsp_err   = exp_err(eop);
            m_known     = 1'b1;
        end else if (rsp_ready) begin
            m_rsp_valid = 1'b0;
            m_known     = 1'b0;
        end
    endtask

    task automatic do_reset();
        int acc;
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
    endtask

    initial begin
        int            acc;
        int            ids [5];
        logic [N-1:0]  eready;
        vec_t          exp_res;

        rst        = 1'b1;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        m_last      = N - 1;
        m_rsp_valid = 1'b0;
        m_rsp_id    = '0;
        m_rsp_res   = '0;
        m_rsp_err   = 1'b0;
        m_known     = 1'b0;
        @(posedge clk);
        #1;
        m_known = 1'b1;

        // Reset holds ready low even with every requester asking
        req_valid = '1;
        for (int i = 0; i < N; i++) new_payload(i);
        do_reset();
        req_valid = '0;
        #2;
        chk("reset_valid", 128'(rsp_valid), 128'(0));
        chk("reset_id", 128'(rsp_id), 128'(0));
        chk("reset_result", 128'(rsp_result), 128'(0));
        chk("reset_err", 128'(rsp_err), 128'(0));

        // Single ADD from requester 0
        req_valid     = 4'b0001;
        req_opcode[0] = 5'b00001;
        for (int l = 0; l < VS; l++) begin
            req_a[0][l] = 32'(l + 1);
            req_b[0][l] = 32'd10;
        end
        #2;
        chk("add_ready", 128'(req_ready), 128'(4'b0001));
        step(acc);
        req_valid = '0;
        exp_res   = '0;
        for (int l = 0; l < VS; l++) exp_res[l] = 32'(11 + l);
        #2;
        chk("add_valid", 128'(rsp_valid), 128'(1));
        chk("add_id", 128'(rsp_id), 128'(0));
        chk("add_result", 128'(rsp_result), 128'(exp_res));
        step(acc);

        // All requesters busy: strict rotation from requester 0
        do_reset();
        req_valid = '1;
        ids = '{0, 1, 2, 3, 0};
        for (int s = 0; s < 5; s++) begin
            #2;
            eready = N'(1) << ids[s];
            chk("rr_ready", 128'(req_ready), 128'(eready));
            if (s > 0) chk("rr_id", 128'(rsp_id), 128'(ids[s-1]));
            step(acc);
        end

        // Back-pressure for 3 cycles, then drain and load together
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        step(acc);
        rsp_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #2;
            chk("stall_ready", 128'(req_ready), 128'(0));
            chk("stall_valid", 128'(rsp_valid), 128'(1));
            chk("stall_id", 128'(rsp_id), 128'(0));
            step(acc);
        end
        rsp_ready = 1'b1;
        #2;
        chk("release_ready", 128'(req_ready), 128'(4'b0010));
        step(acc);
        #2;
        chk("release_valid", 128'(rsp_valid), 128'(1));
        chk("release_id", 128'(rsp_id), 128'(1));

        // Only requesters 2 and 3 with pointer at 3
        do_reset();
        req_valid = 4'b1100;
        ids = '{2, 3, 2, 0, 0};
        for (int s = 0; s < 3; s++) begin
            #2;
            eready = N'(1) << ids[s];
            chk("pair_ready", 128'(req_ready), 128'(eready));
            step(acc);
        end

        // Undefined opcode from requester 1
        do_reset();
        req_valid     = 4'b0010;
        req_opcode[1] = 5'b00111;
        #2;
        chk("badop_ready", 128'(req_ready), 128'(4'b0010));
        step(acc);
        req_valid = '0;
        #2;
        chk("badop_id", 128'(rsp_id), 128'(1));
`ifdef ALU_ARBITER_OPCODE_CHECK_EN
        chk("badop_err", 128'(rsp_err), 128'(1));
`else
        chk("badop_err", 128'(rsp_err), 128'(0));
`endif
        step(acc);

        // Reset while a response is pending discards it
        do_reset();
        req_valid = '1;
        step(acc);
        #2;
        chk("midrst_pending", 128'(rsp_valid), 128'(1));
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        #2;
        chk("midrst_valid", 128'(rsp_valid), 128'(0));
        chk("midrst_ready", 128'(req_ready), 128'(4'b0001));
        step(acc);

        // Random traffic: held requests, occasional withdrawals, random back-pressure
        acc = -1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[IW'(i)] && acc != i && $urandom_range(0, 9) != 0)) begin
                    req_valid[IW'(i)] = ($urandom_range(0, 2) != 0);
                    new_payload(i);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
